// File: rtl/box_downscale_2x2.sv
// box_downscale_2x2: streaming 2x2 box-average downscaler using one half-width line buffer of partial sums
module box_downscale_2x2 #(
  parameter int IN_W  = 410,
  parameter int IN_H  = 361,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             frame_done
);
  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int XW = $clog2(IN_W);
  localparam int YW = $clog2(IN_H);
  localparam int LW = $clog2(OUT_W);
  localparam bit ODD_H = (IN_H % 2) == 1;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic [PIX_W:0]   lb_q [OUT_W];
  logic [PIX_W:0]   lb_rd, lb_wr;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             last_x, last_y, wr_en, prod;
  logic [PIX_W+1:0] sum, rnd;
  // Odd columns are always inside the kept width and odd lines inside the kept
  // height, so only the trailing even line of an odd-height frame needs masking.
  always_comb begin
    last_x       = x_q == XW'(IN_W - 1);
    last_y       = y_q == YW'(IN_H - 1);
    x_d          = in_valid ? (last_x ? '0 : x_q + 1'b1) : x_q;
    y_d          = (in_valid && last_x) ? (last_y ? '0 : y_q + 1'b1) : y_q;
    hold_d       = (in_valid && !x_q[0]) ? in_pixel : hold_q;
    lb_rd        = lb_q[x_q[LW:1]];
    lb_wr        = (PIX_W+1)'(hold_q) + (PIX_W+1)'(in_pixel);
    wr_en        = in_valid && !y_q[0] && x_q[0] && !(ODD_H && last_y);
    prod         = in_valid && y_q[0] && x_q[0];
    sum          = (PIX_W+2)'(lb_rd) + (PIX_W+2)'(hold_q) + (PIX_W+2)'(in_pixel);
    rnd          = sum + (PIX_W+2)'(2);
    out_valid_d  = prod;
    out_pixel_d  = prod ? rnd[PIX_W+1:2] : out_pixel_q;
    out_last_d   = prod && x_q == XW'(2*OUT_W - 1) && y_q == YW'(2*OUT_H - 1);
    frame_done_d = in_valid && last_x && last_y;
  end
  // Control and output registers; line buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end
  // Even lines store horizontal pair sums for the following odd line.
  always_ff @(posedge clk) begin
    if (wr_en) lb_q[x_q[LW:1]] <= lb_wr;
  end
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
endmodule
